mem_access: RTL
===============

// Module: mem_access
// PURPOSE
//  MEM stage directly downstream of the EX/MEM pipeline register. It takes the registered memory
//  request and writeback fields, runs a req/gnt/rvalid transaction on the data bus, and aligns
//  and extends load data. It raises a pipeline stall while a transaction is pending and registers
//  the writeback fields into the MEM/WB boundary.
//  It also flags misaligned accesses and bus timeouts as one-cycle exception pulses.
// PARAMETERS
//  TIMEOUT   default 255   cycles in REQ or WAIT before the transaction is aborted with bus_err_o
//  CNT_W     default 8     timeout counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk           in   1        single clock; all state updates on posedge clk
//  rst           in   1        asynchronous, active-high reset
//  mem_req_i     in   1        memory access requested (from EX/MEM register)
//  mem_we_i      in   1        1 = store, 0 = load
//  mem_raddr_i   in   MemAddrBus  load address
//  mem_waddr_i   in   MemAddrBus  store address
//  mem_wdata_i   in   MemBus   store data; right-justified
//  r_index_i     in   MemIndex    load byte offset = raddr[1:0]
//  w_index_i     in   MemIndex    store byte offset = waddr[1:0]
//  ex_code_i     in   ExCode   LB/LH/LW/LBU/LHU/SB/SH/SW select size and sign; others = non-memory
//  reg_wdata_i   in   RegBus      ALU result for non-load ops
//  reg_we_i      in   1        register write enable
//  reg_waddr_i   in   RegAddrBus  destination register
//  bus_req_o     out  1        data-bus request
//  bus_we_o      out  1        data-bus write
//  bus_addr_o    out  MemAddrBus  word-aligned address: addr & ~3
//  bus_be_o      out  4        byte enables
//  bus_wdata_o   out  MemBus      lane-replicated store data
//  bus_gnt_i     in   1        request accepted; write completes on gnt
//  bus_rvalid_i  in   1        read data valid
//  bus_rdata_i   in   MemBus      read word
//  stall_o       out  1        hold IF..EX/MEM; combinational
//  wb_wdata_o    out  RegBus      registered writeback data
//  wb_we_o       out  1        registered writeback enable
//  wb_waddr_o    out  RegAddrBus  registered writeback register
//  misalign_o    out  1        registered one-cycle pulse
//  bus_err_o     out  1        registered one-cycle pulse
// BEHAVIOUR
//  Reset
//   - State goes to IDLE; counter clears.
//   - All wb_* outputs, misalign_o and bus_err_o go to 0 (wb_waddr_o = ZeroReg).
//   - bus_req_o drops immediately.
//  FSM states: IDLE, REQ, WAIT.
//  Access validity
//   - acc = mem_req_i & memory ex_code & aligned.
//   - Aligned: H requires offset[0] = 0; W requires offset = 0.
//  Bus signals
//   - bus_req_o = (IDLE & acc) | REQ.
//   - bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o are decoded from the held inputs.
//  Transitions
//   - IDLE, acc & gnt: a store is done this cycle; a load moves to WAIT.
//   - IDLE, acc & !gnt: move to REQ.
//   - REQ, gnt: a store is done and returns to IDLE; a load moves to WAIT.
//   - WAIT, rvalid: done; return to IDLE.
//  Stall and done
//   - stall_o = mem_req_i & memory ex_code & aligned & !done & !timeout.
//   - Upstream holds all inputs stable while stall_o = 1.
//  MEM/WB register update
//   - Non-memory ops: wb_* <= reg_* every cycle, giving 1-cycle latency.
//   - Stalled cycle: wb_we_o <= 0 (bubble).
//   - Load done: wb_wdata_o <= aligned/extended rdata, wb_we_o <= reg_we_i.
//   - Store done: wb_we_o <= 0.
//  Byte enables
//   - B: 4'b0001 << off.
//   - H: 4'b0011 << off.
//   - W: 4'b1111.
//  Store data: B is replicated x4; H is replicated x2.
//  Load extraction
//   - Data = rdata >> (off*8), then take the low 8 or 16 bits.
//   - LB/LH sign-extend; LBU/LHU zero-extend.
//  Misaligned access
//   - No bus request is made.
//   - misalign_o <= 1 for one cycle; wb_we_o <= 0; no stall.
//  Timeout
//   - The counter clears on entering REQ or WAIT and increments each cycle there.
//   - cnt == TIMEOUT with no completion: bus_err_o <= 1, wb_we_o <= 0, return to IDLE, stall released.
//  Ignored bus events
//   - rvalid outside WAIT.
//   - gnt outside an asserted request.
//  Reset mid-transaction: an rvalid arriving after reset is ignored.
// STRUCTURE
//  type_pkg: add MemState_e {IDLE, REQ, WAIT} and typedef ByteEn = logic [3:0].
//  opcode_pkg: add helpers is_load(ExCode), is_store(ExCode), acc_size(ExCode).
//  Sub-module mem_lsu_align (combinational): byte enables, store lane replication,
//  load extract/extend.
// TESTING
//  1. ADD, reg_wdata = 32'h1234, waddr = 5, no mem_req -> next cycle wb_wdata_o = 32'h1234,
//     wb_we_o = 1, stall_o = 0.
//  2. SB, waddr = 0x103, wdata = 0xAB, gnt in first cycle -> be = 4'b1000,
//     bus_wdata = 0xABABABAB, addr = 0x100, no stall.
//  3. LB, raddr = 0x201, gnt after 2 cycles, rvalid = 0x0000_80FF 3 cycles later
//     -> stall_o for 5 cycles, then wb_wdata_o = 0xFFFFFF80.
//  4. LHU, raddr = 0x202, rdata = 0xBEEF0000 -> wb_wdata_o = 0x0000BEEF.
//  5. LW at raddr = 0x302 -> no bus_req_o, misalign_o = 1 for one cycle, wb_we_o = 0.
//  6. Load whose rvalid never arrives (TIMEOUT = 4) -> bus_err_o pulse after 4 WAIT cycles, stall released.
//     Then assert rst mid-WAIT -> bus_req_o = 0 immediately; a late rvalid is ignored.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types for the MEM pipeline stage.
//   Bus/register widths, byte-enable type, MEM FSM states, execution codes
//   and small decode helpers for load/store size and sign.
package mem_access_pkg;

    typedef logic [31:0] MemAddrBus;
    typedef logic [31:0] MemBus;
    typedef logic [31:0] RegBus;
    typedef logic [4:0]  RegAddrBus;
    typedef logic [1:0]  MemIndex;
    typedef logic [3:0]  ByteEn;

    localparam RegAddrBus ZeroReg = '0;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} MemState_e;

    typedef enum logic [3:0] {
        EX_NOP, EX_ADD, EX_SUB, EX_AND, EX_OR,
        EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU,
        EX_SB, EX_SH, EX_SW
    } ExCode;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} AccSize_e;

    function automatic logic is_load(input ExCode c);
        return c inside {EX_LB, EX_LH, EX_LW, EX_LBU, EX_LHU};
    endfunction

    function automatic logic is_store(input ExCode c);
        return c inside {EX_SB, EX_SH, EX_SW};
    endfunction

    function automatic logic is_signed_load(input ExCode c);
        return c inside {EX_LB, EX_LH};
    endfunction

    function automatic AccSize_e acc_size(input ExCode c);
        case (c)
            EX_LB, EX_LBU, EX_SB: return SZ_B;
            EX_LH, EX_LHU, EX_SH: return SZ_H;
            default:              return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: combinational lane logic for the MEM stage.
//   ex_code_i  access size/sign select
//   off_i      byte offset within the word
//   st_data_i  right-justified store data  -> st_data_o lane-replicated
//   rdata_i    raw bus read word           -> ld_data_o aligned and extended
//   be_o       byte enables for the access
module mem_lsu_align
    import mem_access_pkg::*;
(
    input  ExCode   ex_code_i,
    input  MemIndex off_i,
    input  MemBus   st_data_i,
    input  MemBus   rdata_i,
    output ByteEn   be_o,
    output MemBus   st_data_o,
    output RegBus   ld_data_o
);

    AccSize_e    size;
    logic        sext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        size = acc_size(ex_code_i);
        sext = is_signed_load(ex_code_i);

        case (off_i)
            2'd0:    ld_byte = rdata_i[7:0];
            2'd1:    ld_byte = rdata_i[15:8];
            2'd2:    ld_byte = rdata_i[23:16];
            default: ld_byte = rdata_i[31:24];
        endcase
        // Halfwords are only ever aligned here, so off_i[1] picks the half.
        ld_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size)
            SZ_B: begin
                be_o      = 4'b0001 << off_i;
                st_data_o = {4{st_data_i[7:0]}};
                ld_data_o = {{24{sext & ld_byte[7]}}, ld_byte};
            end
            SZ_H: begin
                be_o      = 4'b0011 << off_i;
                st_data_o = {2{st_data_i[15:0]}};
                ld_data_o = {{16{sext & ld_half[15]}}, ld_half};
            end
            default: begin
                be_o      = '1;
                st_data_o = st_data_i;
                ld_data_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage.
//   Inputs : EX/MEM request fields (mem_*, r/w_index, ex_code), writeback
//            fields (reg_*), data-bus handshake (bus_gnt_i, bus_rvalid_i,
//            bus_rdata_i).
//   Outputs: data-bus request (bus_*), combinational stall_o, registered
//            MEM/WB fields (wb_*), one-cycle misalign_o / bus_err_o pulses.
//   Runs a req/gnt/rvalid transaction, aborting after TIMEOUT cycles in
//   REQ or WAIT.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      mem_req_i,
    input  logic      mem_we_i,
    input  MemAddrBus mem_raddr_i,
    input  MemAddrBus mem_waddr_i,
    input  MemBus     mem_wdata_i,
    input  MemIndex   r_index_i,
    input  MemIndex   w_index_i,
    input  ExCode     ex_code_i,
    input  RegBus     reg_wdata_i,
    input  logic      reg_we_i,
    input  RegAddrBus reg_waddr_i,
    output logic      bus_req_o,
    output logic      bus_we_o,
    output MemAddrBus bus_addr_o,
    output ByteEn     bus_be_o,
    output MemBus     bus_wdata_o,
    input  logic      bus_gnt_i,
    input  logic      bus_rvalid_i,
    input  MemBus     bus_rdata_i,
    output logic      stall_o,
    output RegBus     wb_wdata_o,
    output logic      wb_we_o,
    output RegAddrBus wb_waddr_o,
    output logic      misalign_o,
    output logic      bus_err_o
);

    MemState_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    RegBus            wb_wdata_q;
    logic             wb_we_q;
    RegAddrBus        wb_waddr_q;
    logic             misalign_q, bus_err_q;

    logic     is_ld, is_st, aligned, acc, mis;
    logic     st_done, ld_done, tmo;
    AccSize_e size;
    MemIndex  off;
    RegBus    ld_data;

    // Direction comes from ex_code; mem_we_i is redundant with it.
    logic unused_we;
    assign unused_we = mem_we_i;

    always_comb begin
        is_ld = is_load(ex_code_i);
        is_st = is_store(ex_code_i);
        size  = acc_size(ex_code_i);
        off   = is_st ? w_index_i : r_index_i;
        case (size)
            SZ_B:    aligned = 1'b1;
            SZ_H:    aligned = ~off[0];
            default: aligned = (off == 2'd0);
        endcase
        acc = mem_req_i & (is_ld | is_st) & aligned;
        mis = mem_req_i & (is_ld | is_st) & ~aligned;

        st_done = acc & is_st & bus_gnt_i & ((state_q == IDLE) | (state_q == REQ));
        ld_done = acc & is_ld & bus_rvalid_i & (state_q == WAIT);
        // A handshake arriving on the last allowed cycle still wins.
        tmo = acc & (cnt_q == CNT_W'(TIMEOUT)) &
              (((state_q == REQ) & ~bus_gnt_i) | ((state_q == WAIT) & ~bus_rvalid_i));

        state_d = state_q;
        case (state_q)
            IDLE: if (acc) state_d = bus_gnt_i ? (is_st ? IDLE : WAIT) : REQ;
            REQ: begin
                if (!acc || tmo)    state_d = IDLE;
                else if (bus_gnt_i) state_d = is_st ? IDLE : WAIT;
            end
            WAIT:    if (!acc || bus_rvalid_i || tmo) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE || state_d != state_q) cnt_d = '0;
        else                                       cnt_d = cnt_q + CNT_W'(1);
    end

    mem_lsu_align u_align (
        .ex_code_i (ex_code_i),
        .off_i     (off),
        .st_data_i (mem_wdata_i),
        .rdata_i   (bus_rdata_i),
        .be_o      (bus_be_o),
        .st_data_o (bus_wdata_o),
        .ld_data_o (ld_data)
    );

    // Gated by rst so the request drops as soon as reset is applied,
    // even while upstream still presents the access.
    assign bus_req_o  = ~rst & (((state_q == IDLE) & acc) | (state_q == REQ));
    assign bus_we_o   = is_st;
    assign bus_addr_o = (is_st ? mem_waddr_i : mem_raddr_i) & ~MemAddrBus'(3);
    assign stall_o    = acc & ~(st_done | ld_done) & ~tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wb_wdata_q <= '0;
            wb_we_q    <= 1'b0;
            wb_waddr_q <= ZeroReg;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            misalign_q <= mis;
            bus_err_q  <= tmo;
            wb_waddr_q <= reg_waddr_i;
            wb_wdata_q <= ld_done ? ld_data : reg_wdata_i;
            // Memory ops write back only on load completion; every other
            // memory cycle (stall, store, misalign, timeout) is a bubble.
            wb_we_q    <= (acc | mis) ? (ld_done & reg_we_i) : reg_we_i;
        end
    end

    assign wb_wdata_o = wb_wdata_q;
    assign wb_we_o    = wb_we_q;
    assign wb_waddr_o = wb_waddr_q;
    assign misalign_o = misalign_q;
    assign bus_err_o  = bus_err_q;

endmodule
